keypad_entry_ctrl: RTL and testbench

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

---
 rtl/keypad_entry_ctrl_pkg.sv | 26 ++
 rtl/keypad_entry_ctrl_idle_timer.sv | 38 +++
 rtl/keypad_entry_ctrl.sv | 171 +++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// keypad_entry_ctrl_pkg
// Shared parameter header for the keypad entry controller: key code constants,
// the default code length, the entry FSM state encoding and a key classifier.
// -----------------------------------------------------------------------------
package keypad_entry_ctrl_pkg;

  localparam int NUM_DIGITS_DEFAULT = 4;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
  localparam logic [3:0] KEY_ENTER     = 4'hA;
  localparam logic [3:0] KEY_BACK      = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2,
    ST_DONE    = 2'd3
  } entry_state_t;

  // True for the decimal digit keys 0-9.
  function automatic logic is_digit(input logic [3:0] code);
    return (code <= KEY_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_idle_timer.sv
// -----------------------------------------------------------------------------
// entry_idle_timer
// Idle counter for the keypad entry controller; only present in builds that
// define ENTRY_TIMEOUT_EN.
//   clk, rst_n : clock, asynchronous active-low reset
//   hold       : restart the idle count this cycle
//   expire     : count has reached TIMEOUT_CYCLES-1 without a hold
// -----------------------------------------------------------------------------
`ifdef ENTRY_TIMEOUT_EN
module entry_idle_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic expire
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_r;

  assign expire = ~hold & (cnt_r == LAST);

  // Idle cycle counter; restarts on hold and after each expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (hold || expire) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + W'(1);
    end
  end

endmodule
`endif

// File: rtl/keypad_entry_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_entry_ctrl
// Collects a NUM_DIGITS BCD code from a debounced keypad, supports backspace,
// compares the submitted entry against a stored code and reports the result.
// Optional build macro: ENTRY_TIMEOUT_EN (auto-clear of a stale entry after
// TIMEOUT_CYCLES idle cycles; without it timeout is tied low).
//   clk, rst_n     : clock, asynchronous active-low reset
//   key_valid/code : keypad key offer (0-9 digit, A enter, B backspace)
//   key_ready      : key is accepted this cycle when key_valid is high
//   clear_entry    : empty the entry buffer (wins over a same-cycle key)
//   accept_digit   : enables key intake
//   load_code      : copy the current entry into the stored code
//   done / match   : full-code submission pulse and comparison result
//   entry_digits   : BCD entry, newest digit in the low nibble
//   digit_count    : number of digits held
//   short_err      : ENTER with an incomplete entry
//   timeout        : entry auto-cleared after idling
// -----------------------------------------------------------------------------
module keypad_entry_ctrl
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS     = NUM_DIGITS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            key_valid,
  input  logic [3:0]                      key_code,
  output logic                            key_ready,
  input  logic                            clear_entry,
  input  logic                            accept_digit,
  input  logic                            load_code,
  output logic                            done,
  output logic                            match,
  output logic [4*NUM_DIGITS-1:0]         entry_digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                            short_err,
  output logic                            timeout
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int EW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_DIGITS);

  entry_state_t  state_r, state_nxt;
  logic [EW-1:0] entry_r, entry_nxt;
  logic [EW-1:0] code_r;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic          match_r;
  logic          short_err_r, short_err_nxt;
  logic          enter_full_s;
  logic          consume_s;
  logic          expire_s;

  // Reset is folded in so no key is offered as accepted while in reset.
  assign key_ready = rst_n & accept_digit & ~done;
  assign consume_s = key_valid & key_ready;

  assign done         = (state_r == ST_DONE);
  assign match        = match_r;
  assign entry_digits = entry_r;
  assign digit_count  = cnt_r;
  assign short_err    = short_err_r;

`ifdef ENTRY_TIMEOUT_EN
  logic hold_s;
  logic timeout_r;

  assign hold_s  = consume_s | clear_entry | (cnt_r == '0) | ~accept_digit;
  assign timeout = timeout_r;

  entry_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hold_s),
    .expire(expire_s)
  );

  // Timeout pulse accompanies the auto-clear edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= expire_s;
    end
  end
`else
  assign expire_s = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Entry buffer update and next-state decode; clear/expiry outrank any key.
  always_comb begin
    entry_nxt     = entry_r;
    cnt_nxt       = cnt_r;
    short_err_nxt = 1'b0;
    enter_full_s  = 1'b0;
    state_nxt     = ST_IDLE;

    if (clear_entry || expire_s) begin
      entry_nxt = '0;
      cnt_nxt   = '0;
    end else if (consume_s) begin
      if (is_digit(key_code)) begin
        if (cnt_r != FULL_CNT) begin
          entry_nxt      = entry_r << 3'd4;
          entry_nxt[3:0] = key_code;
          cnt_nxt        = cnt_r + CW'(1);
        end else begin
          entry_nxt = entry_r;
        end
      end else if (key_code == KEY_BACK) begin
        if (cnt_r != '0) begin
          entry_nxt = entry_r >> 3'd4;
          cnt_nxt   = cnt_r - CW'(1);
        end else begin
          entry_nxt = entry_r;
        end
      end else if (key_code == KEY_ENTER) begin
        if (cnt_r == FULL_CNT) begin
          enter_full_s = 1'b1;
        end else begin
          short_err_nxt = 1'b1;
        end
      end else begin
        // Unused codes are consumed without effect.
        entry_nxt = entry_r;
      end
    end else begin
      entry_nxt = entry_r;
    end

    // State follows the resulting digit count; DONE lasts exactly one cycle.
    if (enter_full_s) begin
      state_nxt = ST_DONE;
    end else if (cnt_nxt == '0) begin
      state_nxt = ST_IDLE;
    end else if (cnt_nxt == FULL_CNT) begin
      state_nxt = ST_FULL;
    end else begin
      state_nxt = ST_COLLECT;
    end
  end

  // State, entry, stored code and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      entry_r     <= '0;
      cnt_r       <= '0;
      code_r      <= '0;
      match_r     <= 1'b0;
      short_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      entry_r     <= entry_nxt;
      cnt_r       <= cnt_nxt;
      short_err_r <= short_err_nxt;
      // Pre-edge entry is copied, so a simultaneous clear does not lose it.
      if (load_code) begin
        code_r <= entry_r;
      end
      if (enter_full_s) begin
        match_r <= (entry_r == code_r);
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_entry_ctrl
// Directed bench for keypad_entry_ctrl (NUM_DIGITS=4, TIMEOUT_CYCLES=8).
// Inputs change 1 time unit after the rising edge and outputs are sampled there.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_keypad_entry_ctrl;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        clear_entry;
  logic        accept_digit;
  logic        load_code;
  logic        done;
  logic        match;
  logic [15:0] entry_digits;
  logic [2:0]  digit_count;
  logic        short_err;
  logic        timeout;

  int tests_run;
  int tests_failed;

  keypad_entry_ctrl #(
    .NUM_DIGITS    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .clear_entry (clear_entry),
    .accept_digit(accept_digit),
    .load_code   (load_code),
    .done        (done),
    .match       (match),
    .entry_digits(entry_digits),
    .digit_count (digit_count),
    .short_err   (short_err),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    key_code  = c;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic do_clear();
    clear_entry = 1'b1;
    step();
    clear_entry = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (key_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_key_ready: got %b want 0", key_ready); end
    tests_run++;
    if ({done, match, short_err, timeout} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags: got %b want 0000", {done, match, short_err, timeout}); end
    tests_run++;
    if (entry_digits !== 16'h0000 || digit_count !== 3'd0) begin tests_failed++; $display("FAIL reset_entry: got %h/%0d want 0000/0", entry_digits, digit_count); end
    step();
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (key_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_after_reset: got %b want 1", key_ready); end
  endtask

  task automatic test_match();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    tests_run++;
    if (entry_digits !== 16'h1234 || digit_count !== 3'd4) begin tests_failed++; $display("FAIL fill_1234: got %h/%0d want 1234/4", entry_digits, digit_count); end
    load_code = 1'b1; step(); load_code = 1'b0;
    do_clear();
    tests_run++;
    if (entry_digits !== 16'h0000 || digit_count !== 3'd0) begin tests_failed++; $display("FAIL clear: got %h/%0d want 0000/0", entry_digits, digit_count); end
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL done_early: got %b want 0", done); end
    press(4'hA);
    tests_run++;
    if (done !== 1'b1 || match !== 1'b1 || entry_digits !== 16'h1234) begin tests_failed++; $display("FAIL enter_match: got done=%b match=%b entry=%h want 1 1 1234", done, match, entry_digits); end
    tests_run++;
    if (key_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_in_done: got %b want 0", key_ready); end
    step();
    tests_run++;
    if (done !== 1'b0 || match !== 1'b1 || digit_count !== 3'd4) begin tests_failed++; $display("FAIL after_done: got done=%b match=%b cnt=%0d want 0 1 4", done, match, digit_count); end
  endtask

  task automatic test_mismatch();
    do_clear();
    press(4'h1); press(4'h2); press(4'h3); press(4'h5); press(4'hA);
    tests_run++;
    if (done !== 1'b1 || match !== 1'b0 || entry_digits !== 16'h1235) begin tests_failed++; $display("FAIL enter_mismatch: got done=%b match=%b entry=%h want 1 0 1235", done, match, entry_digits); end
    step();
    tests_run++;
    if (done !== 1'b0 || match !== 1'b0) begin tests_failed++; $display("FAIL mismatch_hold: got done=%b match=%b want 0 0", done, match); end
  endtask

  task automatic test_backspace();
    do_clear();
    press(4'hB);
    tests_run++;
    if (digit_count !== 3'd0 || entry_digits !== 16'h0000) begin tests_failed++; $display("FAIL back_empty: got %h/%0d want 0000/0", entry_digits, digit_count); end
    press(4'h7); press(4'h8); press(4'hB);
    tests_run++;
    if (entry_digits !== 16'h0007 || digit_count !== 3'd1) begin tests_failed++; $display("FAIL back_shift: got %h/%0d want 0007/1", entry_digits, digit_count); end
    press(4'h9);
    tests_run++;
    if (entry_digits !== 16'h0079 || digit_count !== 3'd2) begin tests_failed++; $display("FAIL back_then_digit: got %h/%0d want 0079/2", entry_digits, digit_count); end
    press(4'hA);
    tests_run++;
    if (short_err !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL short_enter: got short_err=%b done=%b want 1 0", short_err, done); end
    step();
    tests_run++;
    if (short_err !== 1'b0 || done !== 1'b0 || digit_count !== 3'd2) begin tests_failed++; $display("FAIL short_pulse: got short_err=%b done=%b cnt=%0d want 0 0 2", short_err, done, digit_count); end
  endtask

  task automatic test_overflow();
    do_clear();
    press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'h5);
    tests_run++;
    if (entry_digits !== 16'h9876 || digit_count !== 3'd4) begin tests_failed++; $display("FAIL overflow_drop: got %h/%0d want 9876/4", entry_digits, digit_count); end
    // Load and clear together: the stored code must be the pre-clear entry.
    load_code = 1'b1; clear_entry = 1'b1; step(); load_code = 1'b0; clear_entry = 1'b0;
    tests_run++;
    if (digit_count !== 3'd0) begin tests_failed++; $display("FAIL load_clear_count: got %0d want 0", digit_count); end
    press(4'h3);
    key_code = 4'h6; key_valid = 1'b1; clear_entry = 1'b1;
    step();
    key_valid = 1'b0; clear_entry = 1'b0;
    tests_run++;
    if (digit_count !== 3'd0 || entry_digits !== 16'h0000) begin tests_failed++; $display("FAIL clear_priority: got %h/%0d want 0000/0", entry_digits, digit_count); end
    press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'hA);
    tests_run++;
    if (done !== 1'b1 || match !== 1'b1) begin tests_failed++; $display("FAIL load_preclear: got done=%b match=%b want 1 1", done, match); end
    step();
  endtask

  task automatic test_accept_low();
    do_clear();
    accept_digit = 1'b0;
    #1;
    tests_run++;
    if (key_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_gated: got %b want 0", key_ready); end
    press(4'h5);
    tests_run++;
    if (digit_count !== 3'd0) begin tests_failed++; $display("FAIL ignore_when_gated: got %0d want 0", digit_count); end
    accept_digit = 1'b1;
    press(4'hC);
    tests_run++;
    if (digit_count !== 3'd0 || entry_digits !== 16'h0000 || short_err !== 1'b0) begin tests_failed++; $display("FAIL unused_code: got %h/%0d err=%b want 0000/0 0", entry_digits, digit_count, short_err); end
    press(4'h5);
    tests_run++;
    if (entry_digits !== 16'h0005 || digit_count !== 3'd1) begin tests_failed++; $display("FAIL accept_again: got %h/%0d want 0005/1", entry_digits, digit_count); end
  endtask

  task automatic test_timeout();
    do_clear();
    press(4'h3);
    for (int i = 0; i < 7; i++) step();
    tests_run++;
    if (timeout !== 1'b0 || digit_count !== 3'd1) begin tests_failed++; $display("FAIL pre_timeout: got to=%b cnt=%0d want 0 1", timeout, digit_count); end
    step();
`ifdef ENTRY_TIMEOUT_EN
    tests_run++;
    if (timeout !== 1'b1 || digit_count !== 3'd0 || entry_digits !== 16'h0000) begin tests_failed++; $display("FAIL timeout_fire: got to=%b cnt=%0d want 1 0", timeout, digit_count); end
    step();
    tests_run++;
    if (timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_pulse: got %b want 0", timeout); end
`else
    tests_run++;
    if (timeout !== 1'b0 || digit_count !== 3'd1 || entry_digits !== 16'h0003) begin tests_failed++; $display("FAIL no_timeout: got to=%b cnt=%0d want 0 1", timeout, digit_count); end
`endif
  endtask

  task automatic test_reset_during_done();
    do_clear();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
    tests_run++;
    if (done !== 1'b1) begin tests_failed++; $display("FAIL done_before_reset: got %b want 1", done); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({done, match, short_err, timeout, key_ready} !== 5'b00000) begin tests_failed++; $display("FAIL reset_in_done: got %b want 00000", {done, match, short_err, timeout, key_ready}); end
    tests_run++;
    if (entry_digits !== 16'h0000 || digit_count !== 3'd0) begin tests_failed++; $display("FAIL reset_in_done_entry: got %h/%0d want 0000/0", entry_digits, digit_count); end
    step();
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL done_held_in_reset: got %b want 0", done); end
    rst_n = 1'b1;
    #1;
    // Stored code was reset to 0000.
    press(4'h0); press(4'h0); press(4'h0); press(4'h0); press(4'hA);
    tests_run++;
    if (done !== 1'b1 || match !== 1'b1) begin tests_failed++; $display("FAIL code_reset: got done=%b match=%b want 1 1", done, match); end
    step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    key_valid    = 1'b0;
    key_code     = 4'h0;
    clear_entry  = 1'b0;
    accept_digit = 1'b1;
    load_code    = 1'b0;
    test_reset();
    test_match();
    test_mismatch();
    test_backspace();
    test_overflow();
    test_accept_low();
    test_timeout();
    test_reset_during_done();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
